truth_table_scanner: RTL and testbench

- Upstream stimulus/capture stage for the single-output logic-function blocks (gate-level, NAND-only, mux-based and decoder-based implementations).
- Drives every input combination onto the function's inputs, waits a settle window, and samples the function output into a truth-table register.
- Compares the captured table against an expected table and reports pass/fail, the first failing index and the error count.
- Used on-board to verify each lab function automatically instead of toggling switches by hand.

---
 rtl/truth_table_scanner.sv | 156 +++++++++++++++
 tb/tb_truth_table_scanner.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_scanner.sv
// Truth-table scanner: walks every input vector of a single-output function,
// captures its response after a settle window and compares it with an expected table.
// Optional build macro TT_STOP_ON_ERR_EN ends the scan at the first mismatching vector.
module truth_table_scanner #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 2,
  localparam int TW    = 1 << N_IN
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [TW-1:0]     expect_i,
  input  logic              f_i,
  output logic [N_IN-1:0]   drv_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [TW-1:0]     table_o,
  output logic              pass_o,
  output logic [N_IN-1:0]   err_idx_o,
  output logic [N_IN:0]     err_cnt_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    DONE_ST = 2'd2
  } state_e;

  localparam logic [3:0]      SETTLE_CNT = 4'(SETTLE);
  localparam logic [N_IN-1:0] LAST_VEC   = N_IN'(TW - 1);

  state_e            state_q,   state_d;
  logic [N_IN-1:0]   drv_q,     drv_d;
  logic [3:0]        cnt_q,     cnt_d;
  logic [TW-1:0]     exp_q,     exp_d;
  logic [TW-1:0]     table_q,   table_d;
  logic [N_IN-1:0]   err_idx_q, err_idx_d;
  logic [N_IN:0]     err_cnt_q, err_cnt_d;
  logic              pass_q,    pass_d;

  logic              mismatch;
  logic              last_vec;
  logic              scan_end;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      drv_q     <= '0;
      cnt_q     <= '0;
      exp_q     <= '0;
      table_q   <= '0;
      err_idx_q <= '0;
      err_cnt_q <= '0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      drv_q     <= drv_d;
      cnt_q     <= cnt_d;
      exp_q     <= exp_d;
      table_q   <= table_d;
      err_idx_q <= err_idx_d;
      err_cnt_q <= err_cnt_d;
      pass_q    <= pass_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath logic
  // --------------------------------------------------------------------------
  assign mismatch = (f_i != exp_q[drv_q]);
  assign last_vec = (drv_q == LAST_VEC);

`ifdef TT_STOP_ON_ERR_EN
  assign scan_end = last_vec || mismatch;
`else
  assign scan_end = last_vec;
`endif

  // NOTE: every signal gets its hold value first so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    drv_d     = drv_q;
    cnt_d     = cnt_q;
    exp_d     = exp_q;
    table_d   = table_q;
    err_idx_d = err_idx_q;
    err_cnt_d = err_cnt_q;
    pass_d    = pass_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          exp_d     = expect_i;
          table_d   = '0;
          err_idx_d = '0;
          err_cnt_d = '0;
          pass_d    = 1'b0;
          drv_d     = '0;
          cnt_d     = SETTLE_CNT;
          state_d   = HOLD;
        end
      end

      HOLD: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          table_d[drv_q] = f_i;
          if (mismatch) begin
            err_cnt_d = err_cnt_q + (N_IN+1)'(1);
            // Only the first failing vector is reported.
            if (err_cnt_q == '0) begin
              err_idx_d = drv_q;
            end
          end
          if (scan_end) begin
            pass_d  = (err_cnt_d == '0);
            state_d = DONE_ST;
          end else begin
            drv_d = drv_q + N_IN'(1);
            cnt_d = SETTLE_CNT;
          end
        end
      end

      DONE_ST: begin
        drv_d   = '0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    busy_o    = (state_q != IDLE);
    done_o    = (state_q == DONE_ST);
    drv_o     = drv_q;
    table_o   = table_q;
    pass_o    = pass_q;
    err_idx_o = err_idx_q;
    err_cnt_o = err_cnt_q;
  end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner: a table of full scans on an N_IN=4/SETTLE=2
// instance, plus hand-written sequences for restart, reset and a SETTLE=0 instance.
module tb_truth_table_scanner;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        start_a;
  logic [15:0] expect_a;
  logic        f_a;
  logic [3:0]  drv_a;
  logic        busy_a, done_a, pass_a;
  logic [15:0] table_a;
  logic [3:0]  err_idx_a;
  logic [4:0]  err_cnt_a;

  logic        start_b;
  logic [15:0] expect_b;
  logic        f_b;
  logic [3:0]  drv_b;
  logic        busy_b, done_b, pass_b;
  logic [15:0] table_b;
  logic [3:0]  err_idx_b;
  logic [4:0]  err_cnt_b;

  int f_mode;  // 0: lab function, 1: tied high, 2: tied low
  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  truth_table_scanner #(.N_IN(4), .SETTLE(2)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start_a), .expect_i(expect_a), .f_i(f_a),
    .drv_o(drv_a), .busy_o(busy_a), .done_o(done_a), .table_o(table_a),
    .pass_o(pass_a), .err_idx_o(err_idx_a), .err_cnt_o(err_cnt_a)
  );

  truth_table_scanner #(.N_IN(4), .SETTLE(0)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start_b), .expect_i(expect_b), .f_i(f_b),
    .drv_o(drv_b), .busy_o(busy_b), .done_o(done_b), .table_o(table_b),
    .pass_o(pass_b), .err_idx_o(err_idx_b), .err_cnt_o(err_cnt_b)
  );

  // f = a'b' + ad' + bc'd with a = MSB of the driven vector
  function automatic logic lab_func(input logic [3:0] v);
    logic a, b, c, d;
    {a, b, c, d} = v;
    return (!a && !b) || (a && !d) || (b && !c && d);
  endfunction

  always_comb begin
    f_a = 1'b0;
    if (f_mode == 0)      f_a = lab_func(drv_a);
    else if (f_mode == 1) f_a = 1'b1;
    f_b = drv_b[0];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulses START on dut_a and follows the scan until BUSY drops (bounded).
  task automatic run_scan(input logic [15:0] exp, output int lat, output int busy_n);
    @(negedge clk);
    expect_a = exp;
    start_a  = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    lat     = 0;
    busy_n  = 0;
    for (int n = 0; n < 300; n++) begin
      if (!busy_a) break;
      busy_n++;
      if (done_a && lat == 0) lat = n;
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    string       name;
    int          mode;
    logic [15:0] exp;
    logic [15:0] tbl;
    logic        pass;
    logic [4:0]  cnt;
    logic [3:0]  idx;
    int          lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int lat, busy_n;

`ifdef TT_STOP_ON_ERR_EN
    vecs[0] = '{"match",     0, 16'h752F, 16'h752F, 1'b1, 5'd0, 4'd0,  48};
    vecs[1] = '{"two_err",   0, 16'h7727, 16'h000F, 1'b0, 5'd1, 4'd3,  12};
    vecs[2] = '{"all_one",   1, 16'h0000, 16'h0001, 1'b0, 5'd1, 4'd0,   3};
    vecs[3] = '{"exp_zero",  0, 16'h0000, 16'h0001, 1'b0, 5'd1, 4'd0,   3};
    vecs[4] = '{"all_zero",  2, 16'hFFFF, 16'h0000, 1'b0, 5'd1, 4'd0,   3};
    vecs[5] = '{"last_err",  0, 16'hF52F, 16'h752F, 1'b0, 5'd1, 4'd15, 48};
    vecs[6] = '{"first_err", 0, 16'h752E, 16'h0001, 1'b0, 5'd1, 4'd0,   3};
`else
    vecs[0] = '{"match",     0, 16'h752F, 16'h752F, 1'b1, 5'd0,  4'd0,  48};
    vecs[1] = '{"two_err",   0, 16'h7727, 16'h752F, 1'b0, 5'd2,  4'd3,  48};
    vecs[2] = '{"all_one",   1, 16'h0000, 16'hFFFF, 1'b0, 5'd16, 4'd0,  48};
    vecs[3] = '{"exp_zero",  0, 16'h0000, 16'h752F, 1'b0, 5'd10, 4'd0,  48};
    vecs[4] = '{"all_zero",  2, 16'hFFFF, 16'h0000, 1'b0, 5'd16, 4'd0,  48};
    vecs[5] = '{"last_err",  0, 16'hF52F, 16'h752F, 1'b0, 5'd1,  4'd15, 48};
    vecs[6] = '{"first_err", 0, 16'h752E, 16'h752F, 1'b0, 5'd1,  4'd0,  48};
`endif

    rst_n    = 1'b0;
    start_a  = 1'b0;
    start_b  = 1'b0;
    expect_a = '0;
    expect_b = '0;
    f_mode   = 0;
    #1;
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_drv",  32'(drv_a),  32'd0);
    check("rst_tbl",  32'(table_a), 32'd0);
    check("rst_pass", 32'(pass_a), 32'd0);
    check("rst_cnt",  32'(err_cnt_a), 32'd0);
    check("rst_idx",  32'(err_idx_a), 32'd0);
    check("rst_b",    32'({busy_b, done_b, pass_b, drv_b, table_b}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      f_mode = vecs[i].mode;
      run_scan(vecs[i].exp, lat, busy_n);
      check({vecs[i].name, "_lat"},  32'(lat),       32'(vecs[i].lat));
      check({vecs[i].name, "_busy"}, 32'(busy_n),    32'(vecs[i].lat + 1));
      check({vecs[i].name, "_tbl"},  32'(table_a),   32'(vecs[i].tbl));
      check({vecs[i].name, "_pass"}, 32'(pass_a),    32'(vecs[i].pass));
      check({vecs[i].name, "_cnt"},  32'(err_cnt_a), 32'(vecs[i].cnt));
      check({vecs[i].name, "_idx"},  32'(err_idx_a), 32'(vecs[i].idx));
      check({vecs[i].name, "_drv"},  32'(drv_a),     32'd0);
    end

    // Results hold while idle, even with EXPECT moving.
    f_mode   = 0;
    expect_a = 16'h1234;
    repeat (5) @(posedge clk);
    #1;
    check("hold_tbl", 32'(table_a),   32'(vecs[6].tbl));
    check("hold_cnt", 32'(err_cnt_a), 32'(vecs[6].cnt));

    // START and EXPECT changes during a scan are ignored.
    @(negedge clk);
    expect_a = 16'h752F;
    start_a  = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    lat = 0;
    for (int n = 0; n < 300; n++) begin
      if (n == 10) begin start_a = 1'b1; expect_a = 16'h0000; end
      if (n == 11) start_a = 1'b0;
      if (done_a) begin lat = n; break; end
      @(posedge clk);
      #1;
    end
    check("repulse_lat",  32'(lat),       32'd48);
    check("repulse_pass", 32'(pass_a),    32'd1);
    check("repulse_cnt",  32'(err_cnt_a), 32'd0);
    @(posedge clk);
    #1;
    check("repulse_idle", 32'(busy_a), 32'd0);

    // Reset 20 cycles into a scan aborts it with no DONE.
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy_a), 32'd0);
    check("mid_rst_out",  32'({done_a, pass_a, drv_a, err_idx_a, err_cnt_a}), 32'd0);
    check("mid_rst_tbl",  32'(table_a), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_done", 32'(done_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_scan(16'h752F, lat, busy_n);
    check("post_rst_lat",  32'(lat),     32'd48);
    check("post_rst_tbl",  32'(table_a), 32'h752F);
    check("post_rst_pass", 32'(pass_a),  32'd1);

    // START held high: next scan is accepted on the first IDLE cycle after DONE.
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    lat = 0;
    for (int n = 0; n < 300; n++) begin
      if (done_a) begin lat = n; break; end
      @(posedge clk);
      #1;
    end
    check("held_lat", 32'(lat), 32'd48);
    @(posedge clk);
    #1;
    check("held_idle", 32'(busy_a), 32'd0);
    @(posedge clk);
    #1;
    check("held_reaccept", 32'(busy_a), 32'd1);
    check("held_clear",    32'(table_a), 32'd0);
    start_a = 1'b0;
    for (int n = 0; n < 300 && busy_a; n++) begin
      @(posedge clk);
      #1;
    end
    check("held_end_pass", 32'(pass_a), 32'd1);

    // SETTLE=0: a new vector every cycle, DONE after 16 cycles.
    @(negedge clk);
    expect_b = 16'hAAAA;
    start_b  = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("s0_drv%0d", k), 32'(drv_b), 32'(k));
      if (done_b) check("s0_early_done", 32'(done_b), 32'd0);
      @(posedge clk);
      #1;
    end
    check("s0_done", 32'(done_b),    32'd1);
    check("s0_pass", 32'(pass_b),    32'd1);
    check("s0_tbl",  32'(table_b),   32'hAAAA);
    check("s0_cnt",  32'(err_cnt_b), 32'd0);
    @(posedge clk);
    #1;
    check("s0_idle", 32'({busy_b, done_b, drv_b}), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
